// File: rtl/nbr_pkg.sv
// Shared geometry, status codes and FSM state encoding for the neighbour-table writer.
// Optional feature macro: NBR_EVICT_EN (adds the EVICT pass for full-table misses).
package nbr_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 6;
  localparam int CNT_W  = 7;

  localparam int MAX_NBR = 64;

  localparam logic [ADDR_W-1:0] NBR_ID_BASE  = 11'h048;
  localparam logic [ADDR_W-1:0] NBR_CID_BASE = 11'h0C8;
  localparam logic [ADDR_W-1:0] NBR_BAT_BASE = 11'h148;
  localparam logic [ADDR_W-1:0] NBR_QV_BASE  = 11'h1C8;
  localparam logic [ADDR_W-1:0] NBR_CNT_ADDR = 11'h68A;

  localparam logic [1:0] ST_UPDATED  = 2'b00;
  localparam logic [1:0] ST_APPENDED = 2'b01;
  localparam logic [1:0] ST_DROPPED  = 2'b10;
  localparam logic [1:0] ST_EVICTED  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CNT,
    S_SCAN,
    S_WRITE,
    S_WR_CNT,
    S_DONE
`ifdef NBR_EVICT_EN
    ,
    S_EVICT
`endif
  } nbr_state_e;

  // Field order matches the WRITE sequence, so the write phase counter selects the field.
  typedef enum logic [1:0] {
    FLD_ID  = 2'd0,
    FLD_CID = 2'd1,
    FLD_BAT = 2'd2,
    FLD_QV  = 2'd3
  } nbr_field_e;

endpackage

// File: rtl/nbr_addr_gen.sv
// Combinational address map: (field, index) -> byte address BASE_f + 2*index.
module nbr_addr_gen
  import nbr_pkg::*;
(
  input  nbr_field_e        fld,
  input  logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] base;

  // Pick the field base and add the word offset (entries are 2 bytes apart).
  always_comb begin
    base = NBR_ID_BASE;
    case (fld)
      FLD_ID:  base = NBR_ID_BASE;
      FLD_CID: base = NBR_CID_BASE;
      FLD_BAT: base = NBR_BAT_BASE;
      FLD_QV:  base = NBR_QV_BASE;
      default: base = NBR_ID_BASE;
    endcase
    addr = base + {4'b0000, idx, 1'b0};
  end

endmodule

// File: rtl/nbr_table_update.sv
// Neighbour table writer: searches neighborID[], rewrites a matching entry or
// appends a new one and bumps neighborCount. Sole writer of the neighbour tables.
// Optional feature macro: NBR_EVICT_EN -- on a full-table miss, overwrite the entry
// with the smallest qValue instead of dropping the beacon.
module nbr_table_update
  import nbr_pkg::*;
(
  input  logic                clock,
  input  logic                nrst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_nbr_id,
  input  logic [DATA_W-1:0]   in_cluster_id,
  input  logic [DATA_W-1:0]   in_battery,
  input  logic [DATA_W-1:0]   in_qvalue,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_wr_en,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                done,
  output logic [1:0]          status
);

  nbr_state_e        state_q, state_d;
  logic [DATA_W-1:0] id_q, id_d;
  logic [DATA_W-1:0] cid_q, cid_d;
  logic [DATA_W-1:0] bat_q, bat_d;
  logic [DATA_W-1:0] qv_q, qv_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  tgt_q, tgt_d;
  logic [1:0]        wph_q, wph_d;
  logic [1:0]        pend_q, pend_d;
  logic [1:0]        status_q, status_d;
`ifdef NBR_EVICT_EN
  logic [DATA_W-1:0] min_q, min_d;
  logic [IDX_W-1:0]  min_idx_q, min_idx_d;
  logic              new_min;
`endif

  nbr_field_e        ag_fld;
  logic [IDX_W-1:0]  ag_idx;
  logic [ADDR_W-1:0] ag_addr;

  nbr_addr_gen u_addr_gen (
    .fld  (ag_fld),
    .idx  (ag_idx),
    .addr (ag_addr)
  );

  // State and datapath registers; reset returns to IDLE and abandons any beacon.
  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      cid_q     <= '0;
      bat_q     <= '0;
      qv_q      <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tgt_q     <= '0;
      wph_q     <= '0;
      pend_q    <= ST_UPDATED;
      status_q  <= ST_UPDATED;
`ifdef NBR_EVICT_EN
      min_q     <= '0;
      min_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      cid_q     <= cid_d;
      bat_q     <= bat_d;
      qv_q      <= qv_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tgt_q     <= tgt_d;
      wph_q     <= wph_d;
      pend_q    <= pend_d;
      status_q  <= status_d;
`ifdef NBR_EVICT_EN
      min_q     <= min_d;
      min_idx_q <= min_idx_d;
`endif
    end
  end

  // Next-state and memory-port logic; status_q only changes on the edge into DONE.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    cid_d       = cid_q;
    bat_d       = bat_q;
    qv_d        = qv_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    tgt_d       = tgt_q;
    wph_d       = wph_q;
    pend_d      = pend_q;
    status_d    = status_q;
`ifdef NBR_EVICT_EN
    min_d       = min_q;
    min_idx_d   = min_idx_q;
    new_min     = 1'b0;
`endif
    ag_fld      = FLD_ID;
    ag_idx      = '0;
    mem_address = '0;
    mem_wr_en   = 1'b0;
    mem_wdata   = '0;
    done        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          id_d  = in_nbr_id;
          cid_d = in_cluster_id;
          bat_d = in_battery;
          qv_d  = in_qvalue;
          idx_d = '0;
          if (in_nbr_id == '0) begin
            status_d = ST_DROPPED;
            state_d  = S_DONE;
          end else begin
            state_d  = S_RD_CNT;
          end
        end
      end

      S_RD_CNT: begin
        mem_address = NBR_CNT_ADDR;
        // A corrupt count above the table size is clamped so the scan stays in range.
        cnt_d = (mem_rdata > 16'(MAX_NBR)) ? CNT_W'(MAX_NBR) : mem_rdata[CNT_W-1:0];
        if (mem_rdata == '0) begin
          tgt_d   = '0;
          pend_d  = ST_APPENDED;
          wph_d   = '0;
          state_d = S_WRITE;
        end else begin
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        ag_fld      = FLD_ID;
        ag_idx      = idx_q[IDX_W-1:0];
        mem_address = ag_addr;
        if (mem_rdata == id_q) begin
          tgt_d   = idx_q[IDX_W-1:0];
          pend_d  = ST_UPDATED;
          wph_d   = '0;
          state_d = S_WRITE;
        end else if (idx_q == cnt_q - 7'd1) begin
          if (cnt_q == CNT_W'(MAX_NBR)) begin
`ifdef NBR_EVICT_EN
            idx_d   = '0;
            state_d = S_EVICT;
`else
            status_d = ST_DROPPED;
            state_d  = S_DONE;
`endif
          end else begin
            tgt_d   = cnt_q[IDX_W-1:0];
            pend_d  = ST_APPENDED;
            wph_d   = '0;
            state_d = S_WRITE;
          end
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end

`ifdef NBR_EVICT_EN
      S_EVICT: begin
        ag_fld      = FLD_QV;
        ag_idx      = idx_q[IDX_W-1:0];
        mem_address = ag_addr;
        // Strict less-than keeps the earliest index on ties.
        new_min = (idx_q == '0) || (mem_rdata < min_q);
        if (new_min) begin
          min_d     = mem_rdata;
          min_idx_d = idx_q[IDX_W-1:0];
        end
        if (idx_q == CNT_W'(MAX_NBR - 1)) begin
          tgt_d   = new_min ? idx_q[IDX_W-1:0] : min_idx_q;
          pend_d  = ST_EVICTED;
          wph_d   = '0;
          state_d = S_WRITE;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
`endif

      S_WRITE: begin
        ag_fld      = nbr_field_e'(wph_q);
        ag_idx      = tgt_q;
        mem_address = ag_addr;
        mem_wr_en   = 1'b1;
        case (wph_q)
          2'd0:    mem_wdata = id_q;
          2'd1:    mem_wdata = cid_q;
          2'd2:    mem_wdata = bat_q;
          default: mem_wdata = qv_q;
        endcase
        wph_d = wph_q + 2'd1;
        if (wph_q == 2'd3) begin
          if (pend_q == ST_APPENDED) begin
            state_d = S_WR_CNT;
          end else begin
            status_d = pend_q;
            state_d  = S_DONE;
          end
        end
      end

      S_WR_CNT: begin
        // Count goes out only after all four field words are in place.
        mem_address = NBR_CNT_ADDR;
        mem_wr_en   = 1'b1;
        mem_wdata   = {9'd0, cnt_q + 7'd1};
        status_d    = pend_q;
        state_d     = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = (state_q == S_IDLE);
  assign status   = status_q;

endmodule

// File: tb/tb_nbr_table_update.sv
// Directed bench for nbr_table_update with a behavioural table memory.
// Build with +define+NBR_EVICT_EN to check the eviction variant.
module tb_nbr_table_update;

  logic        clock = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_nbr_id, in_cluster_id, in_battery, in_qvalue;
  logic [10:0] mem_address;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        done;
  logic [1:0]  status;

  logic [15:0] mem [0:1023];
  logic [10:0] log_addr [$];
  logic [15:0] log_data [$];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  nbr_table_update dut (
    .clock         (clock),
    .nrst          (nrst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_nbr_id     (in_nbr_id),
    .in_cluster_id (in_cluster_id),
    .in_battery    (in_battery),
    .in_qvalue     (in_qvalue),
    .mem_address   (mem_address),
    .mem_wr_en     (mem_wr_en),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .done          (done),
    .status        (status)
  );

  assign mem_rdata = mem[mem_address[10:1]];

  always @(posedge clock) begin
    if (mem_wr_en) begin
      mem[mem_address[10:1]] = mem_wdata;
      log_addr.push_back(mem_address);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
  endtask

  // IDs 1,3,4,6 at indices 0..3, neighborCount 4.
  task automatic preload_std();
    clear_mem();
    mem[11'h048 >> 1] = 16'd1;
    mem[11'h04A >> 1] = 16'd3;
    mem[11'h04C >> 1] = 16'd4;
    mem[11'h04E >> 1] = 16'd6;
    mem[11'h68A >> 1] = 16'd4;
  endtask

  task automatic run_beacon(input logic [15:0] id, input logic [15:0] cid,
                            input logic [15:0] bat, input logic [15:0] q,
                            output int cyc);
    log_addr.delete();
    log_data.delete();
    @(negedge clock);
    in_valid = 1'b1; in_nbr_id = id; in_cluster_id = cid; in_battery = bat; in_qvalue = q;
    cyc = 0;
    while (cyc < 400) begin
      @(negedge clock);
      in_valid = 1'b0;
      cyc++;
      if (done) break;
    end
    chk("done_seen", {31'd0, done}, 32'd1);
    $display("beacon id=0x%04h done_cycle=%0d status=%0d writes=%0d",
             id, cyc, status, log_addr.size());
    @(negedge clock);
    chk("ready_after_done", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic chk_writes(input string tag, input logic [10:0] a0, input logic [15:0] d0,
                            input logic [10:0] a1, input logic [15:0] d1,
                            input logic [10:0] a2, input logic [15:0] d2,
                            input logic [10:0] a3, input logic [15:0] d3);
    logic [10:0] ea [4];
    logic [15:0] ed [4];
    ea[0] = a0; ea[1] = a1; ea[2] = a2; ea[3] = a3;
    ed[0] = d0; ed[1] = d1; ed[2] = d2; ed[3] = d3;
    for (int k = 0; k < 4; k++) begin
      if (k < log_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, k), {21'd0, log_addr[k]}, {21'd0, ea[k]});
        chk($sformatf("%s_data%0d", tag, k), {16'd0, log_data[k]}, {16'd0, ed[k]});
      end else begin
        chk($sformatf("%s_missing%0d", tag, k), log_addr.size(), k + 1);
      end
    end
  endtask

  initial begin
    int cyc;
    nrst = 1'b0; in_valid = 1'b0;
    in_nbr_id = '0; in_cluster_id = '0; in_battery = '0; in_qvalue = '0;
    clear_mem();
    repeat (3) @(negedge clock);
    nrst = 1'b1;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_status", {30'd0, status}, 32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_address", {21'd0, mem_address}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);

    // Update of existing ID 4 at index 2.
    preload_std();
    run_beacon(16'd4, 16'd5, 16'h4000, 16'h0200, cyc);
    chk("upd_cycle", cyc, 9);
    chk("upd_status", {30'd0, status}, 32'd0);
    chk("upd_nwrites", log_addr.size(), 4);
    chk_writes("upd", 11'h04C, 16'd4, 11'h0CC, 16'd5, 11'h14C, 16'h4000, 11'h1CC, 16'h0200);
    chk("upd_count", {16'd0, mem[11'h68A >> 1]}, 32'd4);

    // Append of new ID 7 at index 4.
    preload_std();
    run_beacon(16'd7, 16'd8, 16'h1234, 16'h0055, cyc);
    chk("app_cycle", cyc, 11);
    chk("app_status", {30'd0, status}, 32'd1);
    chk("app_nwrites", log_addr.size(), 5);
    chk_writes("app", 11'h050, 16'd7, 11'h0D0, 16'd8, 11'h150, 16'h1234, 11'h1D0, 16'h0055);
    if (log_addr.size() == 5) chk("app_last_addr", {21'd0, log_addr[4]}, 32'h68A);
    chk("app_count", {16'd0, mem[11'h68A >> 1]}, 32'd5);

    // Empty table.
    clear_mem();
    run_beacon(16'd2, 16'd9, 16'h7000, 16'h0001, cyc);
    chk("empty_cycle", cyc, 7);
    chk("empty_status", {30'd0, status}, 32'd1);
    chk("empty_id0", {16'd0, mem[11'h048 >> 1]}, 32'd2);
    chk("empty_count", {16'd0, mem[11'h68A >> 1]}, 32'd1);

    // Full table miss; qValue minimum 0x0010 at index 17 and tied again at 40.
    clear_mem();
    for (int i = 0; i < 64; i++) begin
      mem[(11'h048 >> 1) + i] = 16'h1000 + 16'(i);
      mem[(11'h1C8 >> 1) + i] = 16'h2000 + 16'(i);
    end
    mem[(11'h1C8 >> 1) + 17] = 16'h0010;
    mem[(11'h1C8 >> 1) + 40] = 16'h0010;
    mem[11'h68A >> 1] = 16'd64;
    run_beacon(16'h0100, 16'h00AA, 16'h7FFF, 16'h0300, cyc);
`ifdef NBR_EVICT_EN
    chk("full_cycle", cyc, 134);
    chk("full_status", {30'd0, status}, 32'd3);
    chk("full_nwrites", log_addr.size(), 4);
    chk_writes("evict", 11'h06A, 16'h0100, 11'h0EA, 16'h00AA, 11'h16A, 16'h7FFF, 11'h1EA, 16'h0300);
`else
    chk("full_cycle", cyc, 66);
    chk("full_status", {30'd0, status}, 32'd2);
    chk("full_nwrites", log_addr.size(), 0);
`endif
    chk("full_count", {16'd0, mem[11'h68A >> 1]}, 32'd64);

    // Illegal ID 0.
    preload_std();
    run_beacon(16'd0, 16'd1, 16'd1, 16'd1, cyc);
    chk("id0_cycle", cyc, 1);
    chk("id0_status", {30'd0, status}, 32'd2);
    chk("id0_nwrites", log_addr.size(), 0);

    // Reset during the second WRITE cycle (cycle 7) of an append with count 4.
    preload_std();
    @(negedge clock);
    in_valid = 1'b1; in_nbr_id = 16'd9; in_cluster_id = 16'd2;
    in_battery = 16'h0100; in_qvalue = 16'h0020;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
    chk("mid_wr_active", {31'd0, mem_wr_en}, 32'd1);
    nrst = 1'b0;
    @(negedge clock);
    chk("mid_wr_en_low", {31'd0, mem_wr_en}, 32'd0);
    chk("mid_in_ready", {31'd0, in_ready}, 32'd1);
    log_addr.delete();
    log_data.delete();
    nrst = 1'b1;
    repeat (6) @(negedge clock);
    $display("beacon id=0x0009 reset_mid_write writes_after_reset=%0d", log_addr.size());
    chk("mid_no_writes", log_addr.size(), 0);
    chk("mid_count", {16'd0, mem[11'h68A >> 1]}, 32'd4);
    chk("mid_first_field", {16'd0, mem[11'h050 >> 1]}, 32'd9);
    chk("mid_status", {30'd0, status}, 32'd0);
    chk("mid_done", {31'd0, done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
